// File: rtl/dmem_arbiter_if.sv
// Bundle of core-side and memory-side signals around the shared data-memory arbiter.
// The master modport is the arbiter itself; the slave modport is the cores plus the memory.
interface dmem_arbiter_if #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   logic [N_CORES-1:0]        core_req;
   logic [N_CORES-1:0]        core_we;
   logic [2*N_CORES-1:0]      core_size;
   logic [ADDR_W*N_CORES-1:0] core_addr;
   logic [DATA_W*N_CORES-1:0] core_wdata;
   logic [N_CORES-1:0]        core_ack;
   logic [DATA_W-1:0]         core_rdata;
   logic [N_CORES-1:0]        core_stall;

   logic                      mem_en;
   logic                      mem_we;
   logic [1:0]                mem_size;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;

   modport master (
      input  core_req, core_we, core_size, core_addr, core_wdata, mem_rdata,
      output core_ack, core_rdata, core_stall,
             mem_en, mem_we, mem_size, mem_addr, mem_wdata
   );

   modport slave (
      output core_req, core_we, core_size, core_addr, core_wdata, mem_rdata,
      input  core_ack, core_rdata, core_stall,
             mem_en, mem_we, mem_size, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data-memory port among N cores,
// with an issue stage (memory command) and a response stage (ack + read data).
module dmem_arbiter #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic           Clk,
   input  logic           Rst,
   dmem_arbiter_if.master bus
);
   localparam int ID_W = $clog2(N_CORES);
   typedef logic [ID_W-1:0] id_t;

   logic              iss_valid_q, iss_valid_d;
   id_t               iss_id_q, iss_id_d;
   logic              rsp_valid_q, rsp_valid_d;
   id_t               rsp_id_q, rsp_id_d;
   id_t               rr_ptr_q, rr_ptr_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [1:0]        mem_size_q, mem_size_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic [N_CORES-1:0] busy, elig;
   logic               grant;
   id_t                winner;
   logic [1:0]         size_arr  [N_CORES];
   logic [ADDR_W-1:0]  addr_arr  [N_CORES];
   logic [DATA_W-1:0]  wdata_arr [N_CORES];

   // (base + off) mod N_CORES, for base < N_CORES and off < N_CORES.
   function automatic id_t wrap_add(input id_t base, input int unsigned off);
      logic [ID_W:0] sum;
      sum = {1'b0, base} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N_CORES)) sum = sum - (ID_W+1)'(N_CORES);
      return sum[ID_W-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         size_arr[i]  = bus.core_size[2*i +: 2];
         addr_arr[i]  = bus.core_addr[i*ADDR_W +: ADDR_W];
         wdata_arr[i] = bus.core_wdata[i*DATA_W +: DATA_W];
      end
   end

   // A core with an access in either stage may not be granted again.
   always_comb begin
      busy = '0;
      if (iss_valid_q) busy[iss_id_q] = 1'b1;
      if (rsp_valid_q) busy[rsp_id_q] = 1'b1;
      elig = bus.core_req & ~busy;
   end

   always_comb begin
      grant  = 1'b0;
      winner = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (!grant && elig[wrap_add(rr_ptr_q, unsigned'(i))]) begin
            grant  = 1'b1;
            winner = wrap_add(rr_ptr_q, unsigned'(i));
         end
      end
   end

   always_comb begin
      // NOTE: every _d gets a default before any branch so no latch is inferred.
      rsp_valid_d = iss_valid_q;
      rsp_id_d    = iss_id_q;
      iss_valid_d = 1'b0;
      iss_id_d    = iss_id_q;
      rr_ptr_d    = rr_ptr_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_size_d  = mem_size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (grant) begin
         iss_valid_d = 1'b1;
         iss_id_d    = winner;
         rr_ptr_d    = wrap_add(winner, 1);
         mem_en_d    = 1'b1;
         mem_we_d    = bus.core_we[winner];
         mem_size_d  = (size_arr[winner] == 2'b11) ? 2'b00 : size_arr[winner];
         mem_addr_d  = addr_arr[winner];
         mem_wdata_d = wdata_arr[winner];
      end
   end

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (Rst) begin
         iss_valid_q <= 1'b0;
         iss_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rr_ptr_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_size_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         iss_valid_q <= iss_valid_d;
         iss_id_q    <= iss_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rr_ptr_q    <= rr_ptr_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_size_q  <= mem_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.core_ack   = rsp_valid_q ? (N_CORES'(1) << rsp_id_q) : '0;
   assign bus.core_stall = bus.core_req & ~bus.core_ack;
   assign bus.core_rdata = bus.mem_rdata;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_size   = mem_size_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
endmodule
